memory_arbiter: RTL and testbench

Arbitrates the single RAM port between the instruction cache and the data cache. It sits directly downstream of dcache and icache and upstream of RAM. Each cache's miss fill and dirty writeback is serialized onto the RAM port. A granted dcache keeps the port for a full block transfer, so a two-word fill or writeback is never split by an instruction fetch.

---
 rtl/memory_arbiter.sv | 122 ++++++++++++
 tb/tb_memory_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Serializes icache and dcache miss/writeback traffic onto one RAM port; dcache keeps the port for a whole block.
// Optional MEMARB_FAIR_EN selects round-robin on contention instead of strict dcache priority.
module memory_arbiter #(
  parameter int BLOCK_WORDS  = 2,
  parameter int ICACHE_WORDS = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam int MAXW = (BLOCK_WORDS > ICACHE_WORDS) ? BLOCK_WORDS : ICACHE_WORDS;
  localparam int CW   = $clog2(MAXW + 1);
  localparam logic [CW-1:0] D_LAST = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] I_LAST = CW'(ICACHE_WORDS);
  localparam logic [1:0]    RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT_I = 2'd1, GRANT_D = 2'd2} state_t;

  state_t        state;
  logic [CW-1:0] beat_cnt;
  logic          last_grant;

  logic          access;
  logic          d_req;
  logic          i_req;
  logic          fair_mode;
  logic          pick_d;
  logic [CW-1:0] beat_inc;

`ifdef MEMARB_FAIR_EN
  assign fair_mode = 1'b1;
`else
  assign fair_mode = 1'b0;
`endif

  assign access   = (ramstate == RAM_ACCESS);
  assign d_req    = dREN | dWEN;
  assign i_req    = iREN;
  assign beat_inc = beat_cnt + CW'(1);
  // Under contention, round-robin hands the port to whoever did not have it last.
  assign pick_d   = d_req && (!fair_mode || !i_req || !last_grant);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_grant <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (pick_d)     state <= GRANT_D;
          else if (i_req) state <= GRANT_I;
        end
        GRANT_D: begin
          if (!d_req || (access && beat_inc == D_LAST)) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            last_grant <= 1'b1;
          end else if (access) begin
            beat_cnt <= beat_inc;
          end
        end
        GRANT_I: begin
          if (!i_req || (access && beat_inc == I_LAST)) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            last_grant <= 1'b0;
          end else if (access) begin
            beat_cnt <= beat_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM side follows the granted cache combinationally so addresses can move beat to beat.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0;
    ramstore = 32'h0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state)
      GRANT_D: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~access;
      end
      GRANT_I: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = ~access;
      end
      default: ;
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: expected RAM beats are queued at stimulus time and checked by a monitor.
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  memory_arbiter dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] S_IDLE = 0, S_GI = 1, S_GD = 2;
  localparam logic [1:0]  FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  typedef struct {
    logic        is_d;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic d, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] s, input logic [31:0] l);
    beat_t b;
    b.is_d = d; b.ren = r; b.wen = w; b.addr = a; b.store = s; b.load = l;
    exp_q.push_back(b);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every cycle where a cache is released from wait is one RAM beat.
  always @(negedge CLK) begin
    if (!RST && (!iwait || !dwait)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {30'h0, iwait, dwait}, 32'h3);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_ren", 32'(ramREN), 32'(e.ren));
        check("beat_wen", 32'(ramWEN), 32'(e.wen));
        check("beat_addr", ramaddr, e.addr);
        if (e.is_d) begin
          check("beat_dwait", 32'(dwait), 32'h0);
          check("beat_iwait_held", 32'(iwait), 32'h1);
          check("beat_store", ramstore, e.store);
          check("beat_dload", dload, e.load);
        end else begin
          check("beat_iwait", 32'(iwait), 32'h0);
          check("beat_dwait_held", 32'(dwait), 32'h1);
          check("beat_iload", iload, e.load);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    #2;
    check("rst_ramREN", 32'(ramREN), 0);
    check("rst_ramWEN", 32'(ramWEN), 0);
    check("rst_ramaddr", ramaddr, 0);
    check("rst_ramstore", ramstore, 0);
    check("rst_iwait", 32'(iwait), 1);
    check("rst_dwait", 32'(dwait), 1);
    check("rst_state", 32'(dut.state), S_IDLE);
    check("rst_cnt", 32'(dut.beat_cnt), 0);
    check("rst_last", 32'(dut.last_grant), 0);
    step(); step();
    RST = 1'b0;

    // Icache read alone, two BUSY cycles then ACCESS.
    iREN = 1; iaddr = 32'h40;
    #1;
    check("i_idle_state", 32'(dut.state), S_IDLE);
    check("i_idle_ren", 32'(ramREN), 0);
    step();
    ramstate = BUSY;
    #1;
    check("i_c1_ren", 32'(ramREN), 1);
    check("i_c1_addr", ramaddr, 32'h40);
    check("i_c1_iwait", 32'(iwait), 1);
    step();
    #1;
    check("i_busy_state", 32'(dut.state), S_GI);
    check("i_busy_cnt", 32'(dut.beat_cnt), 0);
    step();
    ramstate = ACC; ramload = 32'h8C220004;
    push(0, 1, 0, 32'h40, 0, 32'h8C220004);
    step();
    iREN = 0; ramstate = FREE;
    #1;
    check("i_release_state", 32'(dut.state), S_IDLE);
    check("i_release_ren", 32'(ramREN), 0);

    // Dcache two-word writeback while the icache keeps requesting.
    dWEN = 1; daddr = 32'h100; dstore = 32'hAAAA0000; iREN = 1; iaddr = 32'h80; ramload = 0;
    #1;
    check("wb_idle_wen", 32'(ramWEN), 0);
    step();
    ramstate = ACC;
    push(1, 0, 1, 32'h100, 32'hAAAA0000, 0);
    #1;
    check("wb_b0_state", 32'(dut.state), S_GD);
    step();
    daddr = 32'h104; dstore = 32'hBBBB0000;
    push(1, 0, 1, 32'h104, 32'hBBBB0000, 0);
    #1;
    check("wb_b1_state", 32'(dut.state), S_GD);
    check("wb_b1_cnt", 32'(dut.beat_cnt), 1);
    step();
    dWEN = 0; ramstate = FREE;
    #1;
    check("wb_gap_state", 32'(dut.state), S_IDLE);
    check("wb_gap_iwait", 32'(iwait), 1);
    check("wb_gap_cnt", 32'(dut.beat_cnt), 0);
    check("wb_last", 32'(dut.last_grant), 1);
    step();
    ramstate = ACC; ramload = 32'h11112222;
    push(0, 1, 0, 32'h80, 0, 32'h11112222);
    #1;
    check("wb_then_i_state", 32'(dut.state), S_GI);
    step();
    iREN = 0; ramstate = FREE;
    #1;
    check("i2_last", 32'(dut.last_grant), 0);

    // Dcache read released early by dropping the request.
    dREN = 1; daddr = 32'h200; dstore = 0;
    step();
    ramstate = ACC; ramload = 32'h33334444;
    push(1, 1, 0, 32'h200, 0, 32'h33334444);
    step();
    dREN = 0; ramstate = FREE;
    #1;
    check("drop_state", 32'(dut.state), S_GD);
    check("drop_dwait", 32'(dwait), 1);
    step();
    #1;
    check("drop_release", 32'(dut.state), S_IDLE);
    check("drop_last", 32'(dut.last_grant), 1);

    // Contention in IDLE with last_grant = D.
    iREN = 1; iaddr = 32'hC0; dREN = 1; daddr = 32'h300;
    step();
`ifdef MEMARB_FAIR_EN
    check("contend_state", 32'(dut.state), S_GI);
    ramstate = ACC; ramload = 32'h55556666;
    push(0, 1, 0, 32'hC0, 0, 32'h55556666);
    step();
    iREN = 0; ramstate = FREE;
    step();
`else
    check("contend_state", 32'(dut.state), S_GD);
    iREN = 0;
`endif
    check("contend_d_state", 32'(dut.state), S_GD);

    // Read+write together writes; ERROR mid-block stalls without counting.
    dWEN = 1; dstore = 32'hCAFE0001; ramstate = ACC; ramload = 0;
    push(1, 0, 1, 32'h300, 32'hCAFE0001, 0);
    #1;
    check("rw_wen", 32'(ramWEN), 1);
    check("rw_ren", 32'(ramREN), 0);
    step();
    daddr = 32'h304; dstore = 32'hCAFE0002;
    for (int k = 0; k < 3; k++) begin
      ramstate = ERR;
      #1;
      check("err_dwait", 32'(dwait), 1);
      check("err_cnt", 32'(dut.beat_cnt), 1);
      check("err_state", 32'(dut.state), S_GD);
      step();
    end
    ramstate = ACC;
    push(1, 0, 1, 32'h304, 32'hCAFE0002, 0);
    step();
    dREN = 0; dWEN = 0; ramstate = FREE;
    #1;
    check("err_done_state", 32'(dut.state), S_IDLE);
    check("err_done_cnt", 32'(dut.beat_cnt), 0);

    // Asynchronous reset in the middle of a dcache block.
    dREN = 1; daddr = 32'h400; dstore = 0;
    step();
    ramstate = ACC; ramload = 32'h77778888;
    push(1, 1, 0, 32'h400, 0, 32'h77778888);
    step();
    ramstate = BUSY;
    #1;
    check("pre_rst_ren", 32'(ramREN), 1);
    check("pre_rst_cnt", 32'(dut.beat_cnt), 1);
    #1;
    RST = 1;
    #1;
    check("arst_ren", 32'(ramREN), 0);
    check("arst_wen", 32'(ramWEN), 0);
    check("arst_iwait", 32'(iwait), 1);
    check("arst_dwait", 32'(dwait), 1);
    check("arst_state", 32'(dut.state), S_IDLE);
    check("arst_cnt", 32'(dut.beat_cnt), 0);
    dREN = 0; ramstate = FREE;
    step();
    RST = 0;
    step();
    #1;
    check("post_rst_state", 32'(dut.state), S_IDLE);
    check("post_rst_cnt", 32'(dut.beat_cnt), 0);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
